// File: rtl/key_step_conditioner.sv
// key_step_conditioner
//
// Conditions the raw step key and data switch for the sequence-detector FSM.
// Both inputs are synchronized into the CLOCK_50 domain and debounced. Each
// clean key press produces one single-cycle strobe. The strobe carries the
// debounced switch value and advances a wrapping step counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-input interval in clocks (>= 2)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   CLOCK_50    in   system clock
//   reset_key   in   asynchronous active-high reset
//   key_step_n  in   raw step key, active-low, bouncy, asynchronous
//   sw_data     in   raw data switch, bouncy, asynchronous
//   step_pulse  out  one-clock strobe per debounced press
//   step_bit    out  debounced switch value captured with step_pulse
//   sw_stable   out  current debounced switch level
//   step_count  out  pulses since reset, modulo 256
//   busy        out  key debounce interval in progress

module key_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset_key,
    input  logic       key_step_n,
    input  logic       sw_data,
    output logic       step_pulse,
    output logic       step_bit,
    output logic       sw_stable,
    output logic [7:0] step_count,
    output logic       busy
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_sync_p0;
    logic             key_sync_p1;
    logic             sw_sync_p0;
    logic             sw_sync_p1;
    logic             pressed_sync;
    logic [1:0]       state;
    logic [CNT_W-1:0] kcnt;
    logic [CNT_W-1:0] scnt;

    // Two-flop synchronizers. The key resets to "released" (high) so a key
    // still held down across reset is re-qualified only after it propagates.
    always_ff @(posedge CLOCK_50 or posedge reset_key) begin
        if (reset_key) begin
            key_sync_p0 <= 1'b1;
            key_sync_p1 <= 1'b1;
            sw_sync_p0  <= 1'b0;
            sw_sync_p1  <= 1'b0;
        end else begin
            key_sync_p0 <= key_step_n;
            key_sync_p1 <= key_sync_p0;
            sw_sync_p0  <= sw_data;
            sw_sync_p1  <= sw_sync_p0;
        end
    end

    assign pressed_sync = ~key_sync_p1;

    // Key debounce FSM. A pulse is only possible on the PRESS_WAIT ->
    // PRESSED transition, and PRESSED is left only through a fully
    // qualified release back to IDLE, so one press gives one pulse.
    // step_bit samples sw_stable before any toggle on the same edge.
    always_ff @(posedge CLOCK_50 or posedge reset_key) begin
        if (reset_key) begin
            state      <= IDLE;
            kcnt       <= '0;
            step_pulse <= 1'b0;
            step_bit   <= 1'b0;
            step_count <= 8'd0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_sync) begin
                        state <= PRESS_WAIT;
                        kcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_sync) begin
                        state <= IDLE;
                        kcnt  <= '0;
                    end else if (kcnt == CNT_MAX) begin
                        state      <= PRESSED;
                        step_pulse <= 1'b1;
                        step_bit   <= sw_stable;
                        step_count <= step_count + 8'd1;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed_sync) begin
                        state <= RELEASE_WAIT;
                        kcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_sync) begin
                        state <= PRESSED;
                    end else if (kcnt == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Switch debounce: any disagreement must persist for DEBOUNCE_CYCLES
    // consecutive clocks before the stable level follows it.
    always_ff @(posedge CLOCK_50 or posedge reset_key) begin
        if (reset_key) begin
            scnt      <= '0;
            sw_stable <= 1'b0;
        end else if (sw_sync_p1 == sw_stable) begin
            scnt <= '0;
        end else if (scnt == CNT_MAX) begin
            sw_stable <= ~sw_stable;
            scnt      <= '0;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    assign busy = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule
